// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/gnt request channel plus
// rvalid read-response channel.
//   mem_req    master->slave  request, held until mem_gnt
//   mem_we     master->slave  1=write
//   mem_addr   master->slave  word-aligned address
//   mem_be     master->slave  byte enables, bit i = byte lane i
//   mem_wdata  master->slave  lane-replicated store data
//   mem_gnt    slave->master  request accepted this cycle
//   mem_rvalid slave->master  read data valid
//   mem_rdata  slave->master  read data word
interface load_store_unit_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: takes the EXECUTE-stage effective address, rs2 and
// funct3, runs one access on the data-memory port and returns the extended
// load value for writeback.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, accepted only when idle
//   is_store, funct3    access kind and width/sign, sampled with start
//   addr, store_data    effective address and rs2, sampled with start
//   busy, done          busy from cycle after start through the done pulse
//   load_data           extended load result, held until next start
//   fault, fault_code   01 misaligned, 10 illegal funct3, 11 timeout
//   mem                 data-memory master port
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [31:0]          addr,
  input  logic [31:0]          store_data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          load_data,
  output logic                 fault,
  output logic [1:0]           fault_code,
  load_store_unit_if.master    mem
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     load_data_q, load_data_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DW-1:0]     mem_addr_q, mem_addr_d;
  logic [BW-1:0]     mem_be_q, mem_be_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

  // Request decode on the raw start-cycle inputs; illegal beats misaligned.
  logic          illegal_c, misaligned_c;
  logic [1:0]    dec_code_c;
  logic [BW-1:0] lane_be_c;
  logic [DW-1:0] lane_wdata_c;

  assign illegal_c = is_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                              : ((funct3[1:0] == 2'b11) || (funct3 == 3'b110));
  assign misaligned_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign dec_code_c = illegal_c    ? FC_ILLEGAL  :
                      misaligned_c ? FC_MISALIGN : FC_NONE;

  // Store lane steering; loads always read the whole word.
  always_comb begin
    lane_be_c    = 4'b1111;
    lane_wdata_c = '0;
    if (is_store) begin
      unique case (funct3[1:0])
        2'b00: begin
          lane_be_c    = 4'b0001 << addr[1:0];
          lane_wdata_c = {4{store_data[7:0]}};
        end
        2'b01: begin
          lane_be_c    = addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata_c = {2{store_data[15:0]}};
        end
        default: begin
          lane_be_c    = 4'b1111;
          lane_wdata_c = store_data;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched offset.
  logic [DW-1:0] rd_shift_c;
  logic [15:0]   rd_half_c;
  logic [DW-1:0] ld_ext_c;

  assign rd_shift_c = mem.mem_rdata >> {off_q, 3'b000};
  assign rd_half_c  = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    unique case (funct3_q)
      3'b000:  ld_ext_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      3'b100:  ld_ext_c = {24'b0, rd_shift_c[7:0]};
      3'b001:  ld_ext_c = {{16{rd_half_c[15]}}, rd_half_c};
      3'b101:  ld_ext_c = {16'b0, rd_half_c};
      default: ld_ext_c = mem.mem_rdata;
    endcase
  end

  logic timeout_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          off_d        = addr[1:0];
          cnt_d        = '0;
          load_data_d  = '0;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          if (dec_code_c != FC_NONE) begin
            fault_d      = 1'b1;
            fault_code_d = dec_code_c;
            state_d      = S_DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be_c;
            mem_wdata_d = lane_wdata_c;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A grant in the timeout cycle still completes the access.
        if (mem.mem_gnt || timeout_c) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
        end
        if (mem.mem_gnt) begin
          state_d = is_store_q ? S_DONE : S_WAIT_RESP;
        end else if (timeout_c) begin
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
          state_d      = S_DONE;
        end
      end
      S_WAIT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.mem_rvalid) begin
          load_data_d = ld_ext_c;
          state_d     = S_DONE;
        end else if (timeout_c) begin
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign load_data     = load_data_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses with a scoreboard
// of expected completions checked on every done pulse.
module tb_load_store_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_code;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .fault_code (fault_code),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    int          gnt_dly;  // -1: never granted
    int          rv_dly;   // cycles from gnt to rvalid, -1: never
    logic [31:0] rd;
    logic [31:0] ld;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        spur;     // drive stray rvalid during REQ
  } txn_t;

  typedef struct {
    string       tag;
    logic [31:0] ld;
    logic [1:0]  code;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq({e.tag, ":load_data"}, load_data, e.ld);
        check_eq({e.tag, ":fault"}, 32'(fault), 32'(e.code != 2'b00));
        check_eq({e.tag, ":code"}, 32'(fault_code), 32'(e.code));
      end
    end
  end

  function automatic txn_t mk(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input int gd, input int rv, input logic [31:0] rd,
                              input logic [31:0] ld, input logic [1:0] code,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic spur);
    txn_t t;
    t.tag = tag; t.st = st; t.f3 = f3; t.a = a; t.sd = sd; t.gnt_dly = gd;
    t.rv_dly = rv; t.rd = rd; t.ld = ld; t.code = code; t.be = be; t.wd = wd;
    t.spur = spur;
    return t;
  endfunction

  // Reference model for random legal accesses.
  function automatic txn_t mk_rand(input int idx);
    txn_t        t;
    logic [2:0]  ld_ops [5];
    logic [7:0]  b;
    logic [15:0] h;
    int          k;
    ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    t.tag = $sformatf("rand%0d", idx);
    t.st  = 1'($urandom_range(0, 1));
    t.f3  = t.st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
    t.a   = $urandom;
    t.sd  = $urandom;
    t.rd  = $urandom;
    t.gnt_dly = $urandom_range(0, 1);
    t.rv_dly  = $urandom_range(1, 2);
    t.spur = 1'b0;
    t.code = 2'b00;
    if ((t.f3[1:0] == 2'b01 && t.a[0]) || (t.f3[1:0] == 2'b10 && t.a[1:0] != 2'b00))
      t.code = 2'b01;
    k = int'(t.a[1:0]);
    b = t.rd[8*k +: 8];
    h = t.rd[16*int'(t.a[1]) +: 16];
    t.ld = 32'h0;
    t.be = 4'hF;
    t.wd = 32'h0;
    if (t.code == 2'b00) begin
      if (t.st) begin
        case (t.f3)
          3'b000:  begin t.be = 4'(1 << k); t.wd = {t.sd[7:0], t.sd[7:0], t.sd[7:0], t.sd[7:0]}; end
          3'b001:  begin t.be = t.a[1] ? 4'hC : 4'h3; t.wd = {t.sd[15:0], t.sd[15:0]}; end
          default: begin t.be = 4'hF; t.wd = t.sd; end
        endcase
      end else begin
        case (t.f3)
          3'b000:  t.ld = {{24{b[7]}}, b};
          3'b100:  t.ld = {24'h0, b};
          3'b001:  t.ld = {{16{h[15]}}, h};
          3'b101:  t.ld = {16'h0, h};
          default: t.ld = t.rd;
        endcase
      end
    end
    return t;
  endfunction

  task automatic run_txn(input txn_t t);
    int   nreq;
    int   waitc;
    logic granted;
    exp_t e;
    waitc = 0;
    while (busy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (busy) check_eq({t.tag, ":idle_wait"}, 32'(busy), 32'd0);
    start = 1'b1; is_store = t.st; funct3 = t.f3; addr = t.a; store_data = t.sd;
    e.tag = t.tag; e.ld = t.ld; e.code = t.code;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check_eq({t.tag, ":busy"}, 32'(busy), 32'd1);
    if (t.code == 2'b01 || t.code == 2'b10) begin
      check_eq({t.tag, ":no_req"}, 32'(mem_bus.mem_req), 32'd0);
      check_eq({t.tag, ":done_lat"}, 32'(done), 32'd1);
    end else begin
      nreq = 0;
      granted = 1'b0;
      for (int c = 0; c < int'(TO) + 2 && mem_bus.mem_req; c++) begin
        nreq++;
        check_eq({t.tag, ":addr"}, mem_bus.mem_addr, {t.a[31:2], 2'b00});
        check_eq({t.tag, ":we"}, 32'(mem_bus.mem_we), 32'(t.st));
        check_eq({t.tag, ":be"}, 32'(mem_bus.mem_be), 32'(t.be));
        if (t.st) check_eq({t.tag, ":wdata"}, mem_bus.mem_wdata, t.wd);
        if (t.spur) begin
          mem_bus.mem_rvalid = 1'b1;
          mem_bus.mem_rdata  = 32'h5A5A_A5A5;
        end
        if (c == t.gnt_dly) mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        if (c == t.gnt_dly) begin
          granted = 1'b1;
          break;
        end
      end
      check_eq({t.tag, ":req_drop"}, 32'(mem_bus.mem_req), 32'd0);
      if (!granted) begin
        check_eq({t.tag, ":req_cycles"}, 32'(nreq), 32'(TO));
        check_eq({t.tag, ":done_lat"}, 32'(done), 32'd1);
      end else begin
        check_eq({t.tag, ":req_cycles"}, 32'(nreq), 32'(t.gnt_dly + 1));
        if (t.st) begin
          check_eq({t.tag, ":done_lat"}, 32'(done), 32'd1);
        end else if (t.rv_dly > 0) begin
          repeat (t.rv_dly - 1) @(negedge clk);
          check_eq({t.tag, ":early_done"}, 32'(done), 32'd0);
          mem_bus.mem_rvalid = 1'b1;
          mem_bus.mem_rdata  = t.rd;
          @(negedge clk);
          mem_bus.mem_rvalid = 1'b0;
          check_eq({t.tag, ":done_lat"}, 32'(done), 32'd1);
        end else begin
          repeat (int'(TO) - t.gnt_dly - 1) @(negedge clk);
          check_eq({t.tag, ":done_lat"}, 32'(done), 32'd1);
        end
      end
    end
    @(negedge clk);
    check_eq({t.tag, ":idle_busy"}, 32'(busy), 32'd0);
    check_eq({t.tag, ":idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t dir[$];
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst:busy", 32'(busy), 32'd0);
    check_eq("rst:done", 32'(done), 32'd0);
    check_eq("rst:load_data", load_data, 32'd0);
    check_eq("rst:fault", {29'd0, fault, fault_code}, 32'd0);
    check_eq("rst:req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst:bus", mem_bus.mem_addr | mem_bus.mem_wdata | 32'(mem_bus.mem_be) | 32'(mem_bus.mem_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    dir.push_back(mk("lw",        0, 3'b010, 32'h100, 0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 4'hF, 0, 0));
    dir.push_back(mk("lb",        0, 3'b000, 32'h203, 0, 0, 1, 32'h80FF0000, 32'hFFFFFF80, 2'b00, 4'hF, 0, 0));
    dir.push_back(mk("lbu",       0, 3'b100, 32'h203, 0, 1, 1, 32'h80FF0000, 32'h00000080, 2'b00, 4'hF, 0, 0));
    dir.push_back(mk("sh",        1, 3'b001, 32'h12, 32'hCAFE1234, 3, 0, 0, 0, 2'b00, 4'hC, 32'h12341234, 0));
    dir.push_back(mk("lw_mis",    0, 3'b010, 32'h102, 0, 0, 0, 0, 0, 2'b01, 4'hF, 0, 0));
    dir.push_back(mk("ld_ill",    0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 2'b10, 4'hF, 0, 0));
    dir.push_back(mk("st_ill_mis",1, 3'b101, 32'h33, 0, 0, 0, 0, 0, 2'b10, 4'hF, 0, 0));
    dir.push_back(mk("sh_mis",    1, 3'b001, 32'h13, 0, 0, 0, 0, 0, 2'b01, 4'hF, 0, 0));
    dir.push_back(mk("to_req",    0, 3'b010, 32'h40, 0, -1, 0, 0, 0, 2'b11, 4'hF, 0, 0));
    dir.push_back(mk("to_resp",   0, 3'b010, 32'h50, 0, 0, -1, 0, 0, 2'b11, 4'hF, 0, 0));
    dir.push_back(mk("lh_spur",   0, 3'b001, 32'h106, 0, 2, 1, 32'h80017FFF, 32'hFFFF8001, 2'b00, 4'hF, 0, 1));
    dir.push_back(mk("lhu",       0, 3'b101, 32'h104, 0, 0, 1, 32'h8001F00D, 32'h0000F00D, 2'b00, 4'hF, 0, 0));
    dir.push_back(mk("lbu_edge",  0, 3'b100, 32'h201, 0, 1, 2, 32'h0000C300, 32'h000000C3, 2'b00, 4'hF, 0, 0));
    dir.push_back(mk("sb",        1, 3'b000, 32'h21, 32'h000000A5, 0, 0, 0, 0, 2'b00, 4'h2, 32'hA5A5A5A5, 0));
    dir.push_back(mk("sw",        1, 3'b010, 32'h30, 32'h13579BDF, 1, 0, 0, 0, 2'b00, 4'hF, 32'h13579BDF, 0));
    foreach (dir[i]) run_txn(dir[i]);

    for (int i = 0; i < 12; i++) run_txn(mk_rand(i));

    // start presented during the DONE cycle must be ignored.
    begin
      exp_t e;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h102;
      e.tag = "done_start"; e.ld = 32'h0; e.code = 2'b01;
      sb_q.push_back(e);
      @(negedge clk);
      check_eq("done_start:done", 32'(done), 32'd1);
      is_store = 1'b1; addr = 32'h200;
      @(negedge clk);
      start = 1'b0;
      check_eq("done_start:busy", 32'(busy), 32'd0);
      check_eq("done_start:req", 32'(mem_bus.mem_req), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Reset while waiting for read data, then a stale rvalid.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    start = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    check_eq("rst_mid:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid:busy", 32'(busy), 32'd0);
    check_eq("rst_mid:req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst_mid:out", load_data | 32'(fault_code) | 32'(fault) | 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hFEEDF00D;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_mid:no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check_eq("rst_mid:load_data", load_data, 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
